// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width/parity/stop bits, valid/ready output with status.
// Optional define UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point (+1 cycle latency).
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitIdle} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ones_q, ones_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 perr_q, perr_d;
  logic                 frerr_q, frerr_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 counting;
  logic                 sample_en;
  logic                 bit_val;
  logic                 frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
    end
  end
  assign rx_s = sync_q[1];

  assign counting = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);

`ifdef UART_RX_MAJORITY_EN
  // Decision is taken one cycle after counter zero so that rx_s at -1, 0 and +1 are all visible.
  logic [1:0] hist_q;
  logic       tick_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
      tick_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], rx_s};
      tick_q <= counting && (cnt_q == '0);
    end
  end
  assign sample_en = tick_q;
  assign bit_val   = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample_en = counting && (cnt_q == '0);
  assign bit_val   = rx_s;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!rx_s) state_d = StStart;
      StStart:    if (sample_en) state_d = bit_val ? StIdle : StData;
      StData: begin
        if (sample_en && (idx_q == LastData)) state_d = (PARITY != 0) ? StParity : StStop;
      end
      StParity:   if (sample_en) state_d = StStop;
      StStop: begin
        if (sample_en && (idx_q == LastStop)) begin
          state_d = (ferr_q || !bit_val) ? StWaitIdle : StIdle;
        end
      end
      StWaitIdle: if (rx_s) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    busy       = (state_q != StIdle);
    frame_done = (state_q == StStop) && sample_en && (idx_q == LastStop);
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ones_d     = ones_q;
    ferr_d     = ferr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    perr_d     = perr_q;
    frerr_d    = frerr_q;
    brk_d      = brk_q;
    ovr_d      = 1'b0;

    if (state_q == StIdle) begin
      if (!rx_s) cnt_d = CntHalf;
    end else if (counting) begin
      cnt_d = (cnt_q == '0) ? CntFull : cnt_q - 1'b1;
    end

    if (sample_en) begin
      unique case (state_q)
        StStart: begin
          idx_d  = '0;
          par_d  = 1'b0;
          ones_d = 1'b0;
          ferr_d = 1'b0;
        end
        StData: begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_val;
          ones_d  = ones_q | bit_val;
          idx_d   = (idx_q == LastData) ? '0 : idx_q + 1'b1;
        end
        StParity: begin
          par_d  = par_q ^ bit_val;
          ones_d = ones_q | bit_val;
        end
        StStop: begin
          ferr_d = ferr_q | !bit_val;
          ones_d = ones_q | bit_val;
          idx_d  = idx_q + 1'b1;
        end
        default: ;
      endcase
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // A completed frame always wins: the receiver never stalls on backpressure.
    if (frame_done) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      perr_d     = (PARITY == 1) ? !par_q : (PARITY == 2) ? par_q : 1'b0;
      frerr_d    = ferr_q | !bit_val;
      brk_d      = !(ones_q | bit_val);
      ovr_d      = rx_valid_q && !rx_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ones_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      frerr_q    <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ones_q     <= ones_d;
      ferr_q     <= ferr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      frerr_q    <= frerr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = frerr_q;
  assign rx_break      = brk_q;
  assign overrun_err   = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (16 clk/bit, 8 data bits, even parity, 1 stop bit).
module tb_uart_rx_param;

  localparam int unsigned Cpb = 16;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_break;
  logic       overrun_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed-event log, sampled on the inactive edge.
  int         valid_cnt = 0;
  int         ovr_cnt   = 0;
  logic [7:0] last_data = '0;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;
  logic       last_brk  = 1'b0;

  uart_rx_param #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8),
    .PARITY      (2),
    .STOP_BITS   (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_break     (rx_break),
    .overrun_err  (overrun_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_data <= rx_data;
      last_perr <= rx_parity_err;
      last_ferr <= rx_frame_err;
      last_brk  <= rx_break;
    end
    if (rst_n && overrun_err) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds the line at b for one bit period; entered and left at posedge+1.
  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_inv, input logic stop_b,
                            input int idle_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ par_inv);
    drive_bit(stop_b);
    for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
  endtask

  int base;

  initial begin
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_overrun", 32'(overrun_err), 32'd0);
    check("reset_flags", {29'd0, rx_parity_err, rx_frame_err, rx_break}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Clean frame
    base = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 2);
    check("a5_valid_cycles", 32'(valid_cnt - base), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_flags", {29'd0, last_perr, last_ferr, last_brk}, 32'd0);
    check("a5_idle", 32'(busy), 32'd0);

    // Inverted parity
    base = valid_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 2);
    check("3c_valid_cycles", 32'(valid_cnt - base), 32'd1);
    check("3c_data", 32'(last_data), 32'h3C);
    check("3c_perr", 32'(last_perr), 32'd1);
    check("3c_ferr", 32'(last_ferr), 32'd0);

    // Missing stop bit, then line stuck low
    base = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    check("55_valid_cycles", 32'(valid_cnt - base), 32'd1);
    check("55_data", 32'(last_data), 32'h55);
    check("55_flags", {29'd0, last_perr, last_ferr, last_brk}, 32'b010);
    check("55_held_busy", 32'(busy), 32'd1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("55_release_idle", 32'(busy), 32'd0);
    check("55_no_retrigger", 32'(valid_cnt - base), 32'd1);
    send_frame(8'h96, 1'b0, 1'b1, 2);
    check("96_valid_cycles", 32'(valid_cnt - base), 32'd2);
    check("96_data", 32'(last_data), 32'h96);
    check("96_flags", {29'd0, last_perr, last_ferr, last_brk}, 32'd0);

    // Break
    base = valid_cnt;
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("brk_valid_cycles", 32'(valid_cnt - base), 32'd1);
    check("brk_data", 32'(last_data), 32'h00);
    check("brk_flags", {29'd0, last_perr, last_ferr, last_brk}, 32'b011);
    check("brk_idle", 32'(busy), 32'd0);

    // 4-cycle glitch
    base = valid_cnt;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_busy", 32'(busy), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("glitch_idle", 32'(busy), 32'd0);
    drive_bit(1'b1);
    check("glitch_no_valid", 32'(valid_cnt - base), 32'd0);

    // Overrun under backpressure
    rx_ready = 1'b0;
    base = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    check("ovr_first_valid", 32'(rx_valid), 32'd1);
    check("ovr_first_data", 32'(rx_data), 32'h11);
    send_frame(8'h22, 1'b0, 1'b1, 2);
    check("ovr_pulses", 32'(ovr_cnt - base), 32'd1);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_flags", {29'd0, rx_parity_err, rx_frame_err, rx_break}, 32'd0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("accept_valid_drop", 32'(rx_valid), 32'd0);
    check("accept_no_overrun", 32'(ovr_cnt - base), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
